step_motor_ctrl: RTL and testbench

// - Move-command sequencer for the 3-phase half-step motor driver. Accepts move commands (direction, step count, step period),

---
 rtl/step_motor_pkg.sv | 40 ++++
 rtl/step_phase_seq.sv | 42 ++++
 rtl/step_motor_ctrl.sv | 164 ++++++++++++++++
 tb/tb_step_motor_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_motor_pkg.sv
// Shared types, phase encodings and the half-step sequencing rule for the
// 3-phase step motor controller.
package step_motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Coil patterns as {A,B,C}.
  localparam logic [2:0] PH_OFF = 3'b000;
  localparam logic [2:0] PH_C   = 3'b001;
  localparam logic [2:0] PH_B   = 3'b010;
  localparam logic [2:0] PH_BC  = 3'b011;
  localparam logic [2:0] PH_A   = 3'b100;
  localparam logic [2:0] PH_AC  = 3'b101;
  localparam logic [2:0] PH_AB  = 3'b110;
  localparam logic [2:0] PH_ILL = 3'b111;

  // Next half-step pattern. Released coils always start at C; the illegal
  // all-on pattern recovers to AB regardless of direction.
  function automatic logic [2:0] next_phase(input logic [2:0] ph, input logic dir);
    logic [2:0] nxt;
    nxt = PH_C;
    case (ph)
      PH_OFF: nxt = PH_C;
      PH_ILL: nxt = PH_AB;
      PH_C:   nxt = dir ? PH_BC : PH_AC;
      PH_AC:  nxt = dir ? PH_C  : PH_A;
      PH_A:   nxt = dir ? PH_AC : PH_AB;
      PH_AB:  nxt = dir ? PH_A  : PH_B;
      PH_B:   nxt = dir ? PH_AB : PH_BC;
      PH_BC:  nxt = dir ? PH_B  : PH_C;
      default: nxt = PH_C;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/step_phase_seq.sv
// Coil phase register: advances one half-step on request, or releases all
// coils. Release has priority over advance.
module step_phase_seq
  import step_motor_pkg::*;
(
  input  logic CP,
  input  logic nCR,
  input  logic advance,
  input  logic dir,
  input  logic rel,
  output logic A,
  output logic B,
  output logic C
);

  logic [2:0] phase_q;
  logic [2:0] phase_d;

  // Next phase: hold by default, release or step when asked.
  always_comb begin
    // NOTE: default first so every path assigns phase_d and no latch is inferred.
    phase_d = phase_q;
    if (rel) begin
      phase_d = PH_OFF;
    end else if (advance) begin
      phase_d = next_phase(phase_q, dir);
    end
  end

  // Phase register, coils released on reset.
  always_ff @(posedge CP or negedge nCR) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!nCR) begin
      phase_q <= PH_OFF;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign {A, B, C} = phase_q;

endmodule

// File: rtl/step_motor_ctrl.sv
// Move-command sequencer: accepts (dir, steps, period) commands, paces the
// half-step sequence, tracks signed position, holds torque and then
// releases the coils.
module step_motor_ctrl
  import step_motor_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DIV_W       = 16,
  parameter int POS_W       = 24,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                    CP,
  input  logic                    nCR,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_steps,
  input  logic [DIV_W-1:0]        cmd_period,
  input  logic                    abort,
  output logic                    A,
  output logic                    B,
  output logic                    C,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [CNT_W-1:0]        steps_left,
  output logic signed [POS_W-1:0] position
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   timer_q, timer_d;
  logic [DIV_W-1:0]   reload_q, reload_d;   // max(period,1)-1
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   steps_left_q, steps_left_d;
  logic [POS_W-1:0]   position_q, position_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               zero_pend_q, zero_pend_d;  // zero-step command awaiting its done pulse

  logic accept;
  logic load_cmd;
  logic advance;
  logic rel;

  assign accept   = cmd_valid && (state_q != ST_RUN);
  assign load_cmd = accept && (cmd_steps != '0);

  // FSM next state, step pacing, hold countdown and pulse outputs.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    reload_d     = reload_q;
    dir_d        = dir_q;
    steps_left_d = steps_left_q;
    position_d   = position_q;
    hold_d       = hold_q;
    done_d       = zero_pend_q;
    aborted_d    = 1'b0;
    zero_pend_d  = accept && (cmd_steps == '0);
    advance      = 1'b0;
    rel          = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (abort) begin
          // Abort beats a coincident step tick.
          state_d      = ST_HOLD;
          steps_left_d = '0;
          aborted_d    = 1'b1;
          hold_d       = HOLD_LOAD;
        end else if (timer_q == '0) begin
          advance      = 1'b1;
          steps_left_d = steps_left_q - CNT_W'(1);
          position_d   = dir_q ? position_q - POS_W'(1) : position_q + POS_W'(1);
          timer_d      = reload_q;
          if (steps_left_q == CNT_W'(1)) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
            hold_d  = HOLD_LOAD;
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end

      ST_IDLE, ST_HOLD: begin
        if (state_q == ST_HOLD) begin
          if (hold_q == '0) begin
            rel     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        // A new move from HOLD continues from the energized phase.
        if (load_cmd) begin
          rel          = 1'b0;
          state_d      = ST_RUN;
          steps_left_d = cmd_steps;
          dir_d        = cmd_dir;
          reload_d     = (cmd_period == '0) ? '0 : cmd_period - DIV_W'(1);
          timer_d      = '0;
          hold_d       = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        rel     = 1'b1;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge CP or negedge nCR) begin
    // NOTE: every control flop is reset; there is no storage array here that could be left unreset.
    if (!nCR) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      reload_q     <= '0;
      dir_q        <= 1'b0;
      steps_left_q <= '0;
      position_q   <= '0;
      hold_q       <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      zero_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      reload_q     <= reload_d;
      dir_q        <= dir_d;
      steps_left_q <= steps_left_d;
      position_q   <= position_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      zero_pend_q  <= zero_pend_d;
    end
  end

  step_phase_seq u_phase (
    .CP      (CP),
    .nCR     (nCR),
    .advance (advance),
    .dir     (dir_q),
    .rel     (rel),
    .A       (A),
    .B       (B),
    .C       (C)
  );

  assign busy       = (state_q == ST_RUN);
  assign cmd_ready  = (state_q != ST_RUN);
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_left_q;
  assign position   = position_q;

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Directed bench for step_motor_ctrl: reset, forward/reverse moves, abort,
// zero-step and busy-ignore commands, async reset mid-move, position wrap.
module tb_step_motor_ctrl;

  localparam int HOLD   = 8;
  localparam int W_HOLD = 4;

  logic        CP;
  logic        nCR;
  logic        cmd_valid, cmd_dir, abort;
  logic [15:0] cmd_steps, cmd_period;
  logic        cmd_ready, A, B, C, busy, done, aborted;
  logic [15:0] steps_left;
  logic [23:0] position;

  logic        w_valid, w_dir, w_abort;
  logic [15:0] w_steps, w_period;
  logic        w_ready, w_a, w_b, w_c, w_busy, w_done, w_aborted;
  logic [15:0] w_left;
  logic [3:0]  w_pos;

  logic [2:0] abc, w_abc;
  assign abc   = {A, B, C};
  assign w_abc = {w_a, w_b, w_c};

  int checks = 0;
  int errors = 0;

  logic [2:0] fwd_seq [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};

  step_motor_ctrl #(.CNT_W(16), .DIV_W(16), .POS_W(24), .HOLD_CYCLES(HOLD)) u_dut (
    .CP(CP), .nCR(nCR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .A(A), .B(B), .C(C), .busy(busy), .done(done), .aborted(aborted),
    .steps_left(steps_left), .position(position)
  );

  step_motor_ctrl #(.CNT_W(16), .DIV_W(16), .POS_W(4), .HOLD_CYCLES(W_HOLD)) u_wrap (
    .CP(CP), .nCR(nCR), .cmd_valid(w_valid), .cmd_ready(w_ready), .cmd_dir(w_dir),
    .cmd_steps(w_steps), .cmd_period(w_period), .abort(w_abort),
    .A(w_a), .B(w_b), .C(w_c), .busy(w_busy), .done(w_done), .aborted(w_aborted),
    .steps_left(w_left), .position(w_pos)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    nCR = 1'b0;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; cmd_period = '0; abort = 1'b0;
    w_valid = 1'b0; w_dir = 1'b0; w_steps = '0; w_period = '0; w_abort = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_abc", 32'(abc), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pos", 32'(position), 32'h0);
    check("rst_left", 32'(steps_left), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    nCR = 1'b1;
    tick();

    // Forward: 6 steps, period 4; steps at k+1, k+5, ... k+21
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd6; cmd_period = 16'd4;
    tick();
    cmd_valid = 1'b0;
    check("fwd_accept_busy", 32'(busy), 32'h1);
    check("fwd_accept_ready", 32'(cmd_ready), 32'h0);
    check("fwd_accept_abc", 32'(abc), 32'h0);
    check("fwd_accept_left", 32'(steps_left), 32'd6);
    tick();
    check("fwd_step0_abc", 32'(abc), 32'(fwd_seq[0]));
    check("fwd_step0_left", 32'(steps_left), 32'd5);
    check("fwd_step0_pos", 32'(position), 32'd1);
    for (int i = 1; i < 6; i++) begin
      repeat (3) tick();
      check("fwd_between_abc", 32'(abc), 32'(fwd_seq[i-1]));
      check("fwd_between_done", 32'(done), 32'h0);
      tick();
      check("fwd_step_abc", 32'(abc), 32'(fwd_seq[i]));
    end
    check("fwd_done", 32'(done), 32'h1);
    check("fwd_pos", 32'(position), 32'd6);
    check("fwd_left", 32'(steps_left), 32'd0);
    check("fwd_busy_hold", 32'(busy), 32'h0);
    tick();
    check("fwd_done_pulse", 32'(done), 32'h0);
    check("fwd_hold_abc", 32'(abc), 32'b011);
    check("fwd_hold_ready", 32'(cmd_ready), 32'h1);

    // Reverse from HOLD: 3 steps, period 0 -> consecutive edges
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd3; cmd_period = 16'd0;
    tick();
    cmd_valid = 1'b0;
    check("rev_accept_busy", 32'(busy), 32'h1);
    check("rev_accept_abc", 32'(abc), 32'b011);
    tick();
    check("rev_s1_abc", 32'(abc), 32'b010);
    check("rev_s1_done", 32'(done), 32'h0);
    tick();
    check("rev_s2_abc", 32'(abc), 32'b110);
    tick();
    check("rev_s3_abc", 32'(abc), 32'b100);
    check("rev_done", 32'(done), 32'h1);
    check("rev_pos", 32'(position), 32'd3);
    tick();
    check("rev_done_pulse", 32'(done), 32'h0);
    repeat (6) tick();
    check("rev_hold_last", 32'(abc), 32'b100);
    check("rev_hold_busy", 32'(busy), 32'h0);
    tick();
    check("rev_release", 32'(abc), 32'h0);
    check("rev_idle_ready", 32'(cmd_ready), 32'h1);

    // Abort outside RUN is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_pulse", 32'(aborted), 32'h0);
    check("idle_abort_left", 32'(steps_left), 32'h0);

    // Abort after the 2nd step (not on a tick)
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd10; cmd_period = 16'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("ab1_s1_abc", 32'(abc), 32'b001);
    tick(); tick();
    check("ab1_s2_abc", 32'(abc), 32'b101);
    check("ab1_s2_left", 32'(steps_left), 32'd8);
    check("ab1_s2_pos", 32'(position), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab1_aborted", 32'(aborted), 32'h1);
    check("ab1_no_done", 32'(done), 32'h0);
    check("ab1_left", 32'(steps_left), 32'd0);
    check("ab1_busy", 32'(busy), 32'h0);
    check("ab1_abc", 32'(abc), 32'b101);
    tick();
    check("ab1_pulse", 32'(aborted), 32'h0);
    check("ab1_frozen_abc", 32'(abc), 32'b101);
    check("ab1_frozen_pos", 32'(position), 32'd5);
    repeat (6) tick();
    check("ab1_hold_last", 32'(abc), 32'b101);
    tick();
    check("ab1_release", 32'(abc), 32'h0);

    // Abort coincident with the 3rd step tick
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd10; cmd_period = 16'd2;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    check("ab2_s2_abc", 32'(abc), 32'b101);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab2_aborted", 32'(aborted), 32'h1);
    check("ab2_abc", 32'(abc), 32'b101);
    check("ab2_pos", 32'(position), 32'd7);
    check("ab2_left", 32'(steps_left), 32'd0);

    // Zero-step command during HOLD: done one edge after accept, ABC unchanged
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd0; cmd_period = 16'd5;
    tick();
    cmd_valid = 1'b0;
    check("zero_accept_done", 32'(done), 32'h0);
    tick();
    check("zero_done", 32'(done), 32'h1);
    check("zero_abc", 32'(abc), 32'b101);
    check("zero_busy", 32'(busy), 32'h0);
    tick();
    check("zero_pulse", 32'(done), 32'h0);
    repeat (6) tick();
    check("zero_released", 32'(abc), 32'h0);

    // Commands offered during RUN are ignored
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd3; cmd_period = 16'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("bsy_s1_abc", 32'(abc), 32'b001);
    tick();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd1; cmd_period = 16'd0;
    tick();
    cmd_valid = 1'b0;
    check("bsy_ign_abc", 32'(abc), 32'b001);
    check("bsy_ign_left", 32'(steps_left), 32'd2);
    check("bsy_ign_ready", 32'(cmd_ready), 32'h0);
    tick();
    check("bsy_s2_abc", 32'(abc), 32'b101);
    check("bsy_s2_left", 32'(steps_left), 32'd1);
    tick(); tick(); tick();
    check("bsy_s3_abc", 32'(abc), 32'b100);
    check("bsy_done", 32'(done), 32'h1);
    check("bsy_pos", 32'(position), 32'd10);

    // Asynchronous reset mid-move
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd5; cmd_period = 16'd1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_s1_abc", 32'(abc), 32'b110);
    check("mid_s1_busy", 32'(busy), 32'h1);
    #3;
    nCR = 1'b0;
    #1;
    check("mid_rst_abc", 32'(abc), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_pos", 32'(position), 32'h0);
    check("mid_rst_left", 32'(steps_left), 32'h0);
    check("mid_rst_ready", 32'(cmd_ready), 32'h1);
    tick();
    nCR = 1'b1;
    tick();

    // Position wrap on the 4-bit instance: 8 reverse steps -> -8, one more -> +7
    w_valid = 1'b1; w_dir = 1'b1; w_steps = 16'd8; w_period = 16'd0;
    tick();
    w_valid = 1'b0;
    repeat (8) tick();
    check("wrap_pos_m8", 32'(w_pos), 32'h8);
    check("wrap_abc_8", 32'(w_abc), 32'b011);
    check("wrap_done", 32'(w_done), 32'h1);
    w_valid = 1'b1; w_dir = 1'b1; w_steps = 16'd1; w_period = 16'd0;
    tick();
    w_valid = 1'b0;
    tick();
    check("wrap_pos_p7", 32'(w_pos), 32'h7);
    check("wrap_abc_9", 32'(w_abc), 32'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
